// File: rtl/elastic_pipe_chain.sv
// Elastic valid/ready register chain with per-slot flush and occupancy.
// Define PIPE_PERF_CNT_EN to build the stall/bubble perf counters.
module elastic_pipe_chain #(
    parameter int WIDTH = 64,
    parameter int STAGES = 4,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
);

    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            live;
    logic [STAGES-1:0]            rdy;
    logic [STAGES-1:0]            src_live;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0][WIDTH-1:0] src_data;

    assign live = valid_q & ~flush;

    always_comb begin
        src_live    = '0;
        src_data    = '0;
        src_live[0] = in_valid;
        src_data[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_live[i] = live[i-1];
            src_data[i] = data_q[i-1];
        end
    end

    // A slot is ready unless it and every slot downstream are live and stalled.
    always_comb begin
        logic all_live;
        all_live = 1'b1;
        rdy      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_live = all_live & live[i];
            rdy[i]   = ~all_live | out_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    valid_q[i] <= src_live[i];
                    if (src_live[i]) begin
                        data_q[i] <= src_data[i];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = live[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (!out_valid && bubble_q != 32'hFFFF_FFFF) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`else
    assign stall_cycles  = 32'd0;
    assign bubble_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Scoreboard bench for elastic_pipe_chain: STAGES=4 main instance
// plus a STAGES=1, WIDTH=8 instance.
module tb_elastic_pipe_chain;

    localparam int W = 64;
    localparam int S = 4;

`ifdef PIPE_PERF_CNT_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [S-1:0] flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;
    logic [31:0]  stall_cycles;
    logic [31:0]  bubble_cycles;

    logic         in_valid1;
    logic         in_ready1;
    logic [7:0]   in_data1;
    logic [0:0]   flush1;
    logic         out_valid1;
    logic         out_ready1;
    logic [7:0]   out_data1;
    logic [0:0]   occupancy1;
    logic [31:0]  stall1;
    logic [31:0]  bubble1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n1_out = 0;
    bit sb_en = 1'b0;
    bit sb1_en = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   q1[$];
    int           out_log[$];

    elastic_pipe_chain #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .stall_cycles(stall_cycles),
        .bubble_cycles(bubble_cycles)
    );

    elastic_pipe_chain #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid1),
        .in_ready(in_ready1),
        .in_data(in_data1),
        .flush(flush1),
        .out_valid(out_valid1),
        .out_ready(out_ready1),
        .out_data(out_data1),
        .occupancy(occupancy1),
        .stall_cycles(stall1),
        .bubble_cycles(bubble1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, 64'(exp_q.size()), 0);
    endtask

    task automatic drain1(input string nm, input int budget);
        int n = 0;
        while (q1.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, 64'(q1.size()), 0);
    endtask

    // Monitor: handshakes are sampled on the falling edge, ahead of the
    // rising edge that completes them.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            q1.delete();
        end else begin
            if (sb_en && out_valid && out_ready) begin
                out_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got 0x%0h, want none",
                             out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            if (sb_en && in_valid && in_ready) exp_q.push_back(in_data);
            if (sb1_en && out_valid1 && out_ready1) begin
                n1_out++;
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out1_unexpected: got 0x%0h, want none",
                             out_data1);
                end else begin
                    chk("out1_data", 64'(out_data1), 64'(q1.pop_front()));
                end
            end
            if (sb1_en && in_valid1 && in_ready1) q1.push_back(in_data1);
`ifndef PIPE_PERF_CNT_EN
            chk("perf_zero", {stall_cycles, bubble_cycles}, 64'd0);
`endif
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int base;
        int acc_cyc;
        int d;
        int pr;
        int s0;
        int b0;
        logic [W-1:0] got[$];
        logic [W-1:0] abcd[4];

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        flush = '0;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        in_data1 = '0;
        flush1 = '0;
        out_ready1 = 1'b0;

        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_occ", 64'(occupancy), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", 64'(stall_cycles), 0);
        chk("rst_bubble", 64'(bubble_cycles), 0);
        chk("rst_out_valid1", 64'(out_valid1), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Back-to-back stream with free-running consumer.
        sb_en = 1'b1;
        out_ready = 1'b1;
        base = out_log.size();
        acc_cyc = -1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = 64'(i);
            #1;
            chk("t1_in_ready", 64'(in_ready), 1);
            if (acc_cyc < 0) acc_cyc = cyc;
            step();
        end
        in_valid = 1'b0;
        drain("t1_drain", 30);
        chk("t1_count", 64'(out_log.size() - base), 8);
        if (out_log.size() >= base + 8) begin
            chk("t1_latency", 64'(out_log[base] - acc_cyc), S);
            chk("t1_b2b", 64'(out_log[base+7] - out_log[base]), 7);
        end

        // Fill under back-pressure, then retire and accept together.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 64'h11 + 64'(i);
            step();
        end
        in_data = 64'h15;
        #1;
        chk("t2_occ_full", 64'(occupancy), 4);
        chk("t2_in_ready_full", 64'(in_ready), 0);
        chk("t2_out_data", out_data, 64'h11);
        step();
        chk("t2_hold_occ", 64'(occupancy), 4);
        out_ready = 1'b1;
        #1;
        chk("t2_in_ready_retire", 64'(in_ready), 1);
        step();
        chk("t2_occ_after", 64'(occupancy), 4);
        chk("t2_out_next", out_data, 64'h12);
        in_valid = 1'b0;
        drain("t2_drain", 30);

        // Middle flush while stalled: D then A survive.
        sb_en = 1'b0;
        out_ready = 1'b0;
        abcd[0] = 64'hD;
        abcd[1] = 64'hC;
        abcd[2] = 64'hB;
        abcd[3] = 64'hA;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = abcd[i];
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("t3_occ_full", 64'(occupancy), 4);
        flush = 4'b0110;
        #1;
        chk("t3_in_ready_flush", 64'(in_ready), 1);
        step();
        flush = '0;
        #1;
        chk("t3_occ_after", 64'(occupancy), 2);
        chk("t3_out_data", out_data, 64'hD);
        out_ready = 1'b1;
        got.delete();
        repeat (6) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_data);
        end
        chk("t3_n_out", 64'(got.size()), 2);
        while (got.size() < 2) got.push_back('1);
        chk("t3_first", got[0], 64'hD);
        chk("t3_second", got[1], 64'hA);

        // Flush of the output slot while the consumer is ready.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'hE0;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("t3b_out_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        flush = 4'b1000;
        #1;
        chk("t3b_killed_valid", 64'(out_valid), 0);
        step();
        flush = '0;
        #1;
        chk("t3b_occ", 64'(occupancy), 0);

        // All-ones flush with a concurrent input.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 64'hF0 + 64'(i);
            step();
        end
        in_data = 64'hEE;
        flush = '1;
        #1;
        chk("t3c_in_ready", 64'(in_ready), 1);
        step();
        flush = '0;
        in_valid = 1'b0;
        #1;
        chk("t3c_occ", 64'(occupancy), 1);
        out_ready = 1'b1;
        got.delete();
        repeat (8) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_data);
        end
        chk("t3c_n_out", 64'(got.size()), 1);
        while (got.size() < 1) got.push_back('1);
        chk("t3c_data", got[0], 64'hEE);

        // Asynchronous reset with three entries in flight.
        step();
        sb_en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 64'h21 + 64'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("t4_occ_pre", 64'(occupancy), 3);
        #1;
        reset = 1'b1;
        #1;
        chk("t4_rst_out_valid", 64'(out_valid), 0);
        chk("t4_rst_occ", 64'(occupancy), 0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t4_in_ready_release", 64'(in_ready), 1);
        out_ready = 1'b1;
        base = out_log.size();
        acc_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 64'h31 + 64'(i);
            #1;
            if (acc_cyc < 0 && in_ready) acc_cyc = cyc;
            step();
        end
        in_valid = 1'b0;
        drain("t4_drain", 30);
        chk("t4_count", 64'(out_log.size() - base), 5);
        if (out_log.size() >= base + 5) begin
            chk("t4_latency", 64'(out_log[base] - acc_cyc), S);
            chk("t4_b2b", 64'(out_log[base+4] - out_log[base]), 4);
        end

        // Perf counters: one entry parked at the output for 10 cycles.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'h55;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("t5_out_valid", 64'(out_valid), 1);
        s0 = int'(stall_cycles);
        b0 = int'(bubble_cycles);
        repeat (10) step();
        chk("t5_stall", 64'(int'(stall_cycles) - s0), EXP_STALL);
        chk("t5_bubble", 64'(int'(bubble_cycles) - b0), 0);
        out_ready = 1'b1;
        drain("t5_drain", 10);

        // Random traffic: occupancy and in_ready against in-flight count.
        for (int n = 0; n < 400; n++) begin
            pr = (n < 200) ? 30 : 80;
            in_valid = 1'($urandom_range(0, 1));
            in_data = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 99) < pr);
            #1;
            chk("rnd_occ", 64'(occupancy), 64'(exp_q.size()));
            chk("rnd_in_ready", 64'(in_ready),
                64'((exp_q.size() < S) || out_ready));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("rnd_drain", 30);

        // Single-slot chain under alternating consumer readiness.
        sb1_en = 1'b1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid1 = 1'b1;
            in_data1 = 8'(d);
            out_ready1 = 1'(i % 2);
            #1;
            chk("t6_in_ready", 64'(in_ready1),
                (i == 0) ? 64'd1 : 64'(out_ready1));
            if (in_ready1) d++;
            step();
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        drain1("t6_drain", 10);
        chk("t6_count", 64'(n1_out), 64'(d - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
